sumador_serie: RTL and testbench
================================

# sumador_serie

Bit-serial adder stage placed directly downstream of the ones'-complement block `compl1`. It takes operand A and that block's output `Sal` as operand B. The `cp1` control is reused as carry-in, so the stage computes either A + B or A + ~B + 1 (two's-complement subtraction). The sum is built one bit per clock, LSB first, and the result is delivered with flags over a valid/ready handshake.

## Interface
- `WIDTH`, default 4: operand and result width in bits. Must be 2 or more.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset. Asynchronous and active-low.
- `in_valid` input 1: an operand pair is presented.
- `in_ready` output 1: the stage can accept operands. Asserted only in IDLE.
- `A` input WIDTH: operand A.
- `B` input WIDTH: operand B, driven by `compl1` `Sal`.
- `Cin` input 1: carry-in, tied to `compl1` `cp1` at the ALU level.
- `out_valid` output 1: the result and flags are valid.
- `out_ready` input 1: the consumer takes the result.
- `Sal` output WIDTH: sum.
- `Cout` output 1: carry out of the MSB.
- `V` output 1: signed overflow.
- `Z` output 1: result is zero.

## Operation
- FSM with three states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: load A and B into internal shift registers, load the carry register with `Cin`, clear the bit counter, go to SHIFT.
- SHIFT, each cycle:
  - Full-add the A and B shift-register LSBs with the carry register.
  - Shift the sum bit into the MSB of the partial-result register; shift A and B right by one.
  - Update the carry register; increment the counter.
  - When the counter is at WIDTH-1, save the carry entering the MSB bit.
  - On the cycle that processes bit WIDTH-1: copy the partial result to `Sal`, set `Cout`, `V` = carry into MSB XOR carry out, `Z` = (sum==0). Go to DONE.
- DONE:
  - `out_valid`=1.
  - `Sal`/`Cout`/`V`/`Z` held stable until `out_valid`&&`out_ready`, then go to IDLE.
- Arithmetic is modulo 2^WIDTH. `Cout` is the unsigned carry, and for subtraction it means "no borrow".
- Input changes outside the IDLE accept edge are ignored. A and B need only be stable on the accept edge.
- The counter is sized $clog2(WIDTH) bits and never wraps past WIDTH-1.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `Sal`=0, `Cout`=0, `V`=0, `Z`=0. Internal shift registers, carry and counter are all 0.
- Latency: accept on edge k, `out_valid` rises after edge k+WIDTH. With WIDTH=4 that is 4 cycles.
- Throughput: one operation per WIDTH+2 cycles at best (accept, WIDTH shift cycles, one cycle in DONE with `out_ready`=1).
- `in_ready` is a registered-state decode: 0 throughout SHIFT and DONE.
- Output registers retain the last result through IDLE, until the next operation's final SHIFT cycle.
- Reset mid-operation, in any state: immediate return to reset values and the in-flight result is discarded.
- `out_ready` is ignored outside DONE.

## Configuration
- `SUMADOR_FLAGS_EN` defined: the `V` and `Z` logic and registers are built as described above.
- `SUMADOR_FLAGS_EN` not defined: `V` and `Z` are constant 0 and the MSB-carry capture register is removed. `Sal`, `Cout`, handshake and timing are unchanged.

## Structure
- Shared package `alu_pkg`:
  - FSM state enum (IDLE, SHIFT, DONE).
  - Default-width constant `ALU_WIDTH`=4.
- One sub-module, `sumador_completo`: a 1-bit full adder (a, b, cin → s, cout), instantiated once per stage for the serial bit.

## Test plan
- Subtraction: A=0110, `compl1` Ent=0010 with cp1=1 (B=1101, Cin=1) → after 4 cycles `Sal`=0100, `Cout`=1, `V`=0, `Z`=0.
- Overflow: A=0111, B=0001, Cin=0 → `Sal`=1000, `Cout`=0, `V`=1, `Z`=0.
- Zero: A=0101, B=1010, Cin=1 → `Sal`=0000, `Cout`=1, `Z`=1, `V`=0. Also A=1111, B=1111, Cin=0 → `Sal`=1110, `Cout`=1, `V`=0.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE → `out_valid` stays 1, outputs stable, `in_ready`=0. Raising `out_ready` gives `in_ready`=1 the next cycle.
- Ignored input: `in_valid`=1 with new A/B during SHIFT → the operation completes with the originally latched operands.
- Reset mid-SHIFT: drop `rst_n` after 2 SHIFT cycles → `out_valid`=0, `Sal`=0 and all flags 0 immediately. After release, `in_ready`=1 and a new operation completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial-adder FSM states and the default datapath width.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int ALU_WIDTH = 4;

endpackage

// File: rtl/sumador_serie_if.sv
// Operand/result handshake bundle for the bit-serial adder stage.
interface sumador_serie_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sal;
  logic             Cout;
  logic             V;
  logic             Z;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sal, Cout, V, Z
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sal, Cout, V, Z
  );

endinterface

// File: rtl/sumador_completo.sv
// One-bit full adder used for the serial sum bit.
module sumador_completo (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sumador_serie.sv
// Bit-serial adder, LSB first, with valid/ready handshake on both sides.
// Define SUMADOR_FLAGS_EN to build the V (signed overflow) and Z (zero) flags.
module sumador_serie
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic            clk,
  input logic            rst_n,
  sumador_serie_if.slave bus
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, part_q, sal_q;
  logic [CNT_W-1:0] cnt_q;
  logic             c_q, cout_q;
  logic             s_bit, c_bit;
  logic             accept, last_bit;
  logic [WIDTH-1:0] part_nxt;

  sumador_completo u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (s_bit),
    .cout (c_bit)
  );

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
  assign part_nxt = {s_bit, part_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Sal       = sal_q;
  assign bus.Cout      = cout_q;

  // Serial datapath: operands shift right, sum bits enter from the MSB side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      part_q <= '0;
      sal_q  <= '0;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.A;
      b_q   <= bus.B;
      c_q   <= bus.Cin;
      cnt_q <= '0;
    end else if (state_q == SHIFT) begin
      a_q    <= a_q >> 1;
      b_q    <= b_q >> 1;
      c_q    <= c_bit;
      part_q <= part_nxt;
      if (last_bit) begin
        sal_q  <= part_nxt;
        cout_q <= c_bit;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef SUMADOR_FLAGS_EN
  logic msb_c_q, z_q;

  // On the MSB cycle the carry register holds the carry entering the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_c_q <= 1'b0;
      z_q     <= 1'b0;
    end else if (last_bit) begin
      msb_c_q <= c_q;
      z_q     <= (part_nxt == '0);
    end
  end

  assign bus.V = msb_c_q ^ cout_q;
  assign bus.Z = z_q;
`else
  assign bus.V = 1'b0;
  assign bus.Z = 1'b0;
`endif

endmodule

// File: tb/tb_sumador_serie.sv
// Self-checking bench for sumador_serie: directed vectors, random operations,
// backpressure, ignored inputs during SHIFT and reset mid-operation.
module tb_sumador_serie;
  import alu_pkg::*;

  localparam int W     = 4;
  localparam int BOUND = 20;

  typedef struct packed {
    logic [W-1:0] sal;
    logic         cout;
    logic         v;
    logic         z;
  } res_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  sumador_serie_if #(.WIDTH(W)) bus ();

  sumador_serie #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    res_t r;
    int   tot, sa, sb, ss;
    tot    = int'(a) + int'(b) + int'(cin);
    r.sal  = W'(tot % (1 << W));
    r.cout = (tot >= (1 << W));
    sa     = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb     = b[W-1] ? int'(b) - (1 << W) : int'(b);
    ss     = sa + sb + int'(cin);
`ifdef SUMADOR_FLAGS_EN
    r.v    = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
    r.z    = (r.sal == '0);
`else
    r.v    = 1'b0;
    r.z    = 1'b0;
`endif
    return r;
  endfunction

  // Drive one operand pair and return just after the accept edge
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    for (int i = 0; i < BOUND && !bus.in_ready; i++) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A        = W'($urandom);
    bus.B        = W'($urandom);
    bus.Cin      = 1'($urandom);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < BOUND) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++;
    if ({bus.Sal, bus.Cout, bus.V, bus.Z} !== '0)
      begin errors++; $display("FAIL reset_outputs got Sal=%b Cout=%b V=%b Z=%b want all 0", bus.Sal, bus.Cout, bus.V, bus.Z); end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4] = '{4'b0110, 4'b0111, 4'b0101, 4'b1111};
    logic [W-1:0] vb [4] = '{4'b1101, 4'b0001, 4'b1010, 4'b1111};
    logic         vc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    res_t exp;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      exp = model(va[i], vb[i], vc[i]);
      accept_op(va[i], vb[i], vc[i]);
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL dir%0d_in_ready_shift got=%b want=0", i, bus.in_ready); end
      wait_done(lat);
      checks++;
      if (lat !== W) begin errors++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, W); end
      checks++;
      if ({bus.Sal, bus.Cout, bus.V, bus.Z} !== exp)
        begin errors++; $display("FAIL dir%0d_result got Sal=%b Cout=%b V=%b Z=%b want Sal=%b Cout=%b V=%b Z=%b",
          i, bus.Sal, bus.Cout, bus.V, bus.Z, exp.sal, exp.cout, exp.v, exp.z); end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         c;
    res_t         exp;
    int           lat;
    for (int n = 0; n < 40; n++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      c   = 1'($urandom);
      exp = model(a, b, c);
      accept_op(a, b, c);
      wait_done(lat);
      checks++;
      if (lat !== W) begin errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, lat, W); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      checks++;
      if ({bus.Sal, bus.Cout, bus.V, bus.Z} !== exp)
        begin errors++; $display("FAIL rnd%0d_result a=%b b=%b cin=%b got=%b_%b%b%b want=%b_%b%b%b",
          n, a, b, c, bus.Sal, bus.Cout, bus.V, bus.Z, exp.sal, exp.cout, exp.v, exp.z); end
      release_out();
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_in_ready_after got=%b want=1", n, bus.in_ready); end
    end
  endtask

  task automatic test_backpressure();
    res_t exp;
    int   lat;
    exp = model(4'b1001, 4'b0011, 1'b0);
    accept_op(4'b1001, 4'b0011, 1'b0);
    wait_done(lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10)
        begin errors++; $display("FAIL bp%0d_handshake got out_valid=%b in_ready=%b want 1/0", i, bus.out_valid, bus.in_ready); end
      checks++;
      if ({bus.Sal, bus.Cout, bus.V, bus.Z} !== exp)
        begin errors++; $display("FAIL bp%0d_hold got=%b_%b%b%b want=%b_%b%b%b", i, bus.Sal, bus.Cout, bus.V, bus.Z,
          exp.sal, exp.cout, exp.v, exp.z); end
    end
    release_out();
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01)
      begin errors++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
    @(posedge clk); #1;
    checks++;
    if ({bus.Sal, bus.Cout, bus.V, bus.Z} !== exp)
      begin errors++; $display("FAIL bp_idle_retain got=%b_%b%b%b want=%b_%b%b%b", bus.Sal, bus.Cout, bus.V, bus.Z,
        exp.sal, exp.cout, exp.v, exp.z); end
  endtask

  task automatic test_ignored_input();
    res_t exp;
    int   lat;
    exp = model(4'b0011, 4'b0100, 1'b0);
    accept_op(4'b0011, 4'b0100, 1'b0);
    bus.in_valid = 1'b1;
    bus.A        = 4'b1111;
    bus.B        = 4'b1110;
    bus.Cin      = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    wait_done(lat);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ign_done got out_valid=%b want=1", bus.out_valid); end
    checks++;
    if ({bus.Sal, bus.Cout, bus.V, bus.Z} !== exp)
      begin errors++; $display("FAIL ign_result got=%b_%b%b%b want=%b_%b%b%b", bus.Sal, bus.Cout, bus.V, bus.Z,
        exp.sal, exp.cout, exp.v, exp.z); end
    release_out();
  endtask

  task automatic test_reset_mid_shift();
    res_t exp;
    int   lat;
    accept_op(4'b0110, 4'b0011, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b want=0", bus.out_valid); end
    checks++;
    if ({bus.Sal, bus.Cout, bus.V, bus.Z} !== '0)
      begin errors++; $display("FAIL rst_mid_outputs got Sal=%b Cout=%b V=%b Z=%b want all 0", bus.Sal, bus.Cout, bus.V, bus.Z); end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got=%b want=1", bus.in_ready); end
    exp = model(4'b1100, 4'b0111, 1'b1);
    accept_op(4'b1100, 4'b0111, 1'b1);
    wait_done(lat);
    checks++;
    if (lat !== W) begin errors++; $display("FAIL rst_mid_latency got=%0d want=%0d", lat, W); end
    checks++;
    if ({bus.Sal, bus.Cout, bus.V, bus.Z} !== exp)
      begin errors++; $display("FAIL rst_mid_result got=%b_%b%b%b want=%b_%b%b%b", bus.Sal, bus.Cout, bus.V, bus.Z,
        exp.sal, exp.cout, exp.v, exp.z); end
    release_out();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_ignored_input();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
